uart_mmio_responder: RTL

//  Memory-mapped UART responder on the CPU peripheral bus (rd/wr/addr/wdata/rdata), addresses 0x40000018..0x40000020.

---
 rtl/uart_mmio_responder.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio_responder.sv
// Memory-mapped UART at 0x40000018 (TXD), 0x4000001C (RXD), 0x40000020 (CON).
// TX bytes queue in a small FIFO; RX delivers one byte at a time with sticky error flags.
module uart_mmio_responder #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout,
  input  logic        UART_RX,
  output logic        UART_TX
);

  localparam int unsigned DIV  = CLK_HZ / BAUD;
  localparam int unsigned CntW = $clog2(DIV);
  localparam int unsigned PtrW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} st_e;

  logic sel_txd, sel_rxd, sel_con;
  assign sel_txd = (addr == 32'h4000_0018);
  assign sel_rxd = (addr == 32'h4000_001C);
  assign sel_con = (addr == 32'h4000_0020);

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  // TX FIFO
  logic [7:0]    fifo_q [TX_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0] count_q;
  logic          push, pop, drop_set, tx_empty, tx_busy;

  st_e             tx_st_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [2:0]      tx_bit_q;
  logic [7:0]      tx_sh_q;
  logic            tx_q;
  logic            tx_last;

  assign tx_last  = (tx_cnt_q == CntW'(DIV - 1));
  assign tx_empty = (count_q == '0);
  assign tx_busy  = (tx_st_q != StIdle);
  // Full check uses the pre-pop count, so a same-cycle pop never rescues a push.
  assign push     = wr && sel_txd && (count_q != (PtrW + 1)'(TX_DEPTH));
  assign drop_set = wr && sel_txd && (count_q == (PtrW + 1)'(TX_DEPTH));
  assign pop      = !tx_empty && ((tx_st_q == StIdle) || (tx_st_q == StStop && tx_last));

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + (PtrW + 1)'(1);
      else if (!push && pop) count_q <= count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_st_q  <= StIdle;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      unique case (tx_st_q)
        StIdle: begin
          if (pop) begin
            tx_st_q  <= StStart;
            tx_cnt_q <= '0;
            tx_sh_q  <= fifo_q[rd_ptr_q];
            tx_q     <= 1'b0;
          end
        end
        StStart: begin
          if (tx_last) begin
            tx_st_q  <= StData;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_q     <= tx_sh_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (tx_last) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_st_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_sh_q  <= tx_sh_q >> 1;
              tx_q     <= tx_sh_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (tx_last) begin
            tx_cnt_q <= '0;
            if (pop) begin
              tx_st_q <= StStart;
              tx_sh_q <= fifo_q[rd_ptr_q];
              tx_q    <= 1'b0;
            end else begin
              tx_st_q <= StIdle;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

  assign UART_TX = tx_q;

  // RX path
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  st_e             rx_st_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_sh_q;
  logic            rx_last, rx_half, stop_smp, deliver, ferr_set;

  assign rx_last  = (rx_cnt_q == CntW'(DIV - 1));
  assign rx_half  = (rx_cnt_q == CntW'(DIV / 2 - 1));
  assign stop_smp = (rx_st_q == StStop) && rx_last;
  assign deliver  = stop_smp && rx_s2_q;
  assign ferr_set = stop_smp && !rx_s2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= StIdle;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      rx_s1_q   <= UART_RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      unique case (rx_st_q)
        StIdle: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_st_q  <= StStart;
            rx_cnt_q <= '0;
          end
        end
        StStart: begin
          if (rx_half) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_st_q  <= rx_s2_q ? StIdle : StData;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (rx_last) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_q <= StStop;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (rx_last) begin
            rx_cnt_q <= '0;
            rx_st_q  <= StIdle;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

  // Control/status and interrupt
  logic       tx_irq_en_q, rx_irq_en_q, rx_valid_q, ovr_q, drop_q, ferr_q, irq_q;
  logic [7:0] rx_byte_q;
  logic       rd_clr, con_wr, load;

  assign rd_clr = rd && sel_rxd;
  assign con_wr = wr && sel_con;
  assign load   = deliver && (!rx_valid_q || rd_clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_irq_en_q <= 1'b0;
      rx_irq_en_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= '0;
      ovr_q       <= 1'b0;
      drop_q      <= 1'b0;
      ferr_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (con_wr) begin
        tx_irq_en_q <= wdata[0];
        rx_irq_en_q <= wdata[1];
      end
      if (load) begin
        rx_valid_q <= 1'b1;
        rx_byte_q  <= rx_sh_q;
      end else if (rd_clr) begin
        rx_valid_q <= 1'b0;
      end
      if (deliver && !load)         ovr_q  <= 1'b1;
      else if (con_wr && wdata[5])  ovr_q  <= 1'b0;
      if (drop_set)                 drop_q <= 1'b1;
      else if (con_wr && wdata[6])  drop_q <= 1'b0;
      if (ferr_set)                 ferr_q <= 1'b1;
      else if (con_wr && wdata[7])  ferr_q <= 1'b0;
      irq_q <= (rx_irq_en_q & rx_valid_q) | (tx_irq_en_q & tx_empty & ~tx_busy);
    end
  end

  assign irqout = irq_q;

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_rxd) begin
        rdata = {24'b0, rx_byte_q};
      end else if (sel_con) begin
        rdata = {24'b0, ferr_q, drop_q, ovr_q, tx_busy, rx_valid_q, tx_empty,
                 rx_irq_en_q, tx_irq_en_q};
      end
    end
  end

endmodule
